dt_scan_ctrl: RTL and testbench

Sequencer for the distance-transform engine. Reads the binary image from the 1-bit-per-pixel sti ROM and initialises the res RAM. It then runs a forward raster pass and a backward raster pass over res, computing the 8-neighbour chessboard distance with a local min accumulator, and raises `done`. It sits directly between the two testbench-side memories; no other requester shares them.

---
 rtl/dt_pkg.sv | 27 ++
 rtl/dt_pixel_cnt.sv | 66 ++++++
 rtl/dt_scan_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_dt_scan_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/dt_pkg.sv
// Shared types and constants for the distance-transform scan controller.
package dt_pkg;

    localparam int unsigned IMG_LOG2_DEF = 7;
    localparam int unsigned DIST_W_DEF   = 8;

    typedef enum logic [4:0] {
        IDLE, LD_RD, LD_LAT, LD_WR,
        FW_C, FW_N1, FW_N2, FW_N3, FW_N4, FW_LAST, FW_WR,
        BW_C, BW_N1, BW_N2, BW_N3, BW_N4, BW_LAST, BW_WR,
        DONE
    } dt_state_e;

    // Two's-complement 2-bit row/col offsets, indexed by neighbour number 0..3
    // forward: NW, N, NE, W    backward: E, SW, S, SE
    localparam logic [3:0][1:0] FW_DR = {2'b00, 2'b11, 2'b11, 2'b11};
    localparam logic [3:0][1:0] FW_DC = {2'b11, 2'b01, 2'b00, 2'b11};
    localparam logic [3:0][1:0] BW_DR = {2'b01, 2'b01, 2'b01, 2'b00};
    localparam logic [3:0][1:0] BW_DC = {2'b01, 2'b00, 2'b11, 2'b01};

    function automatic logic is_border(input logic [15:0] row,
                                       input logic [15:0] col,
                                       input logic [15:0] max_idx);
        return (row == '0) || (col == '0) || (row == max_idx) || (col == max_idx);
    endfunction

endpackage

// File: rtl/dt_pixel_cnt.sv
// Interior row/col scan counter; provides the centre address and the selected
// neighbour address for the current pass direction.
module dt_pixel_cnt
    import dt_pkg::*;
#(
    parameter int unsigned IMG_LOG2 = IMG_LOG2_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init_fw,
    input  logic                  init_bw,
    input  logic                  step,
    input  logic                  bw,
    input  logic [1:0]            nbr_idx,
    output logic [2*IMG_LOG2-1:0] centre_addr,
    output logic [2*IMG_LOG2-1:0] nbr_addr,
    output logic                  last
);

    localparam logic [IMG_LOG2-1:0] LO = IMG_LOG2'(1);
    localparam logic [IMG_LOG2-1:0] HI = IMG_LOG2'((2**IMG_LOG2) - 2);

    logic [IMG_LOG2-1:0] row, col, nrow, ncol;
    logic [1:0]          dr, dc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row <= LO;
            col <= LO;
        end else if (init_fw) begin
            row <= LO;
            col <= LO;
        end else if (init_bw) begin
            row <= HI;
            col <= HI;
        end else if (step) begin
            if (!bw) begin
                if (col == HI) begin
                    col <= LO;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end else begin
                if (col == LO) begin
                    col <= HI;
                    row <= row - 1'b1;
                end else begin
                    col <= col - 1'b1;
                end
            end
        end
    end

    always_comb begin
        dr   = bw ? BW_DR[nbr_idx] : FW_DR[nbr_idx];
        dc   = bw ? BW_DC[nbr_idx] : FW_DC[nbr_idx];
        nrow = row + {{(IMG_LOG2-2){dr[1]}}, dr};
        ncol = col + {{(IMG_LOG2-2){dc[1]}}, dc};
    end

    assign centre_addr = {row, col};
    assign nbr_addr    = {nrow, ncol};
    assign last        = bw ? ((row == LO) && (col == LO)) : ((row == HI) && (col == HI));

endmodule

// File: rtl/dt_scan_ctrl.sv
// Distance-transform sequencer: load sti into res, forward then backward
// chessboard pass. Optional macro DT_FAST_SKIP_EN skips background pixels early.
module dt_scan_ctrl
    import dt_pkg::*;
#(
    parameter int unsigned IMG_LOG2 = IMG_LOG2_DEF,
    parameter int unsigned DIST_W   = DIST_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  done,
    output logic                  sti_rd,
    output logic [2*IMG_LOG2-5:0] sti_addr,
    input  logic [15:0]           sti_di,
    output logic                  res_wr,
    output logic                  res_rd,
    output logic [2*IMG_LOG2-1:0] res_addr,
    output logic [DIST_W-1:0]     res_do,
    input  logic [DIST_W-1:0]     res_di
);

    localparam int unsigned AW      = 2*IMG_LOG2;
    localparam int unsigned WW      = 2*IMG_LOG2 - 4;
    localparam logic [15:0] MAX_IDX = 16'((2**IMG_LOG2) - 1);

    dt_state_e state, state_nxt;

    logic [WW-1:0]     word_q;
    logic [3:0]        k_q;
    logic [15:0]       sti_q;
    logic [DIST_W-1:0] centre_q, min_q, min_fold, min_inc;
    logic [AW-1:0]     ld_addr, centre_addr, nbr_addr;
    logic              cnt_init_fw, cnt_init_bw, cnt_step, cnt_last, pass_bw;
    logic [1:0]        nbr_idx;
    logic              k_en, sti_ld, min_init, min_en, centre_ld, adv, skip_bg, ld_bit;

    assign ld_addr  = {word_q, k_q};
    assign min_fold = (res_di < min_q) ? res_di : min_q;
    assign min_inc  = (min_q == '1) ? min_q : min_q + 1'b1;
    assign pass_bw  = state inside {BW_C, BW_N1, BW_N2, BW_N3, BW_N4, BW_LAST, BW_WR};
    assign ld_bit   = sti_q[4'd15 - k_q] &&
                      !is_border(16'(ld_addr[AW-1:IMG_LOG2]), 16'(ld_addr[IMG_LOG2-1:0]), MAX_IDX);

`ifdef DT_FAST_SKIP_EN
    assign skip_bg = (res_di == '0);
`else
    assign skip_bg = 1'b0;
`endif

    always_comb begin
        nbr_idx = 2'd0;
        unique case (state)
            FW_N2, BW_N2: nbr_idx = 2'd1;
            FW_N3, BW_N3: nbr_idx = 2'd2;
            FW_N4, BW_N4: nbr_idx = 2'd3;
            default:      nbr_idx = 2'd0;
        endcase
    end

    dt_pixel_cnt #(.IMG_LOG2(IMG_LOG2)) u_cnt (
        .clk         (clk),
        .reset       (reset),
        .init_fw     (cnt_init_fw),
        .init_bw     (cnt_init_bw),
        .step        (cnt_step),
        .bw          (pass_bw),
        .nbr_idx     (nbr_idx),
        .centre_addr (centre_addr),
        .nbr_addr    (nbr_addr),
        .last        (cnt_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_q   <= '0;
            k_q      <= '0;
            sti_q    <= '0;
            centre_q <= '0;
            min_q    <= '0;
        end else begin
            if (k_en) begin
                k_q <= k_q + 1'b1;
                if (k_q == '1) word_q <= word_q + 1'b1;
            end
            if (sti_ld)    sti_q    <= sti_di;
            if (centre_ld) centre_q <= res_di;
            if (min_init)      min_q <= '1;
            else if (min_en)   min_q <= min_fold;
        end
    end

    always_comb begin
        state_nxt   = state;
        done        = 1'b0;
        sti_rd      = 1'b0;
        sti_addr    = '0;
        res_rd      = 1'b0;
        res_wr      = 1'b0;
        res_addr    = '0;
        res_do      = '0;
        cnt_init_fw = 1'b0;
        cnt_init_bw = 1'b0;
        cnt_step    = 1'b0;
        k_en        = 1'b0;
        sti_ld      = 1'b0;
        min_init    = 1'b0;
        min_en      = 1'b0;
        centre_ld   = 1'b0;
        adv         = 1'b0;

        unique case (state)
            IDLE: state_nxt = LD_RD;
            LD_RD: begin
                sti_rd    = 1'b1;
                sti_addr  = word_q;
                state_nxt = LD_LAT;
            end
            LD_LAT: begin
                sti_ld    = 1'b1;
                state_nxt = LD_WR;
            end
            LD_WR: begin
                res_wr   = 1'b1;
                res_addr = ld_addr;
                res_do   = {{(DIST_W-1){1'b0}}, ld_bit};
                k_en     = 1'b1;
                if (k_q == '1) begin
                    if (word_q == '1) begin
                        state_nxt   = FW_C;
                        cnt_init_fw = 1'b1;
                    end else begin
                        state_nxt = LD_RD;
                    end
                end
            end
            FW_C, BW_C: begin
                res_rd    = 1'b1;
                res_addr  = centre_addr;
                min_init  = 1'b1;
                state_nxt = pass_bw ? BW_N1 : FW_N1;
            end
            FW_N1, BW_N1: begin
                centre_ld = 1'b1;
                if (skip_bg) begin
                    adv = 1'b1;
                end else begin
                    res_rd    = 1'b1;
                    res_addr  = nbr_addr;
                    state_nxt = pass_bw ? BW_N2 : FW_N2;
                end
            end
            FW_N2, BW_N2, FW_N3, BW_N3, FW_N4, BW_N4: begin
                res_rd   = 1'b1;
                res_addr = nbr_addr;
                min_en   = 1'b1;
                unique case (state)
                    FW_N2:   state_nxt = FW_N3;
                    BW_N2:   state_nxt = BW_N3;
                    FW_N3:   state_nxt = FW_N4;
                    BW_N3:   state_nxt = BW_N4;
                    FW_N4:   state_nxt = FW_LAST;
                    default: state_nxt = BW_LAST;
                endcase
            end
            FW_LAST, BW_LAST: begin
                min_en    = 1'b1;
                state_nxt = pass_bw ? BW_WR : FW_WR;
            end
            FW_WR, BW_WR: begin
                // A zero centre is background; its res word must stay 0.
                res_wr   = (centre_q != '0);
                res_addr = centre_addr;
                res_do   = (pass_bw && (centre_q < min_inc)) ? centre_q : min_inc;
                adv      = 1'b1;
            end
            DONE: done = 1'b1;
            default: state_nxt = IDLE;
        endcase

        if (adv) begin
            if (cnt_last) begin
                if (pass_bw) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt   = BW_C;
                    cnt_init_bw = 1'b1;
                end
            end else begin
                cnt_step  = 1'b1;
                state_nxt = pass_bw ? BW_C : FW_C;
            end
        end
    end

endmodule

// File: tb/tb_dt_scan_ctrl.sv
// Scoreboard bench for dt_scan_ctrl on a 32x32 image with 3-bit distances.
module tb_dt_scan_ctrl;

    localparam int L      = 5;
    localparam int DW     = 3;
    localparam int SIDE   = 32;
    localparam int NWORD  = 64;
    localparam int NPIX   = 1024;
    localparam int DMAX   = 7;
    localparam int BUDGET = 20000;

    logic            clk = 1'b0;
    logic            reset;
    logic            done, sti_rd, res_wr, res_rd;
    logic [2*L-5:0]  sti_addr;
    logic [15:0]     sti_di = '0;
    logic [2*L-1:0]  res_addr;
    logic [DW-1:0]   res_do;
    logic [DW-1:0]   res_di = '0;

    logic [15:0]     sti_mem [NWORD];
    logic [DW-1:0]   res_mem [NPIX];
    bit              img [SIDE][SIDE];

    typedef struct {
        string tag;
        int    addr;
        int    exp;
    } exp_t;
    exp_t sb[$];

    int checks = 0, passed = 0, fails = 0, overlap = 0;

    always #5 clk = ~clk;

    dt_scan_ctrl #(.IMG_LOG2(L), .DIST_W(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .done     (done),
        .sti_rd   (sti_rd),
        .sti_addr (sti_addr),
        .sti_di   (sti_di),
        .res_wr   (res_wr),
        .res_rd   (res_rd),
        .res_addr (res_addr),
        .res_do   (res_do),
        .res_di   (res_di)
    );

    always @(posedge clk) begin
        if (sti_rd) sti_di <= sti_mem[sti_addr];
        if (res_wr) res_mem[res_addr] <= res_do;
        if (res_rd) res_di <= res_mem[res_addr];
    end

    always @(negedge clk)
        if (reset === 1'b1 && ((res_rd && res_wr) || (sti_rd && (res_rd || res_wr))))
            overlap++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit bg(input int r, input int c);
        return (r == 0) || (c == 0) || (r == SIDE-1) || (c == SIDE-1) || !img[r][c];
    endfunction

    task automatic clear_img(input bit v);
        for (int r = 0; r < SIDE; r++)
            for (int c = 0; c < SIDE; c++)
                img[r][c] = v;
    endtask

    task automatic push(input string tag, input int r, input int c, input int exp);
        sb.push_back('{tag, r*SIDE + c, exp});
    endtask

    // Brute-force chessboard distance to the nearest background pixel, clamped.
    task automatic push_model(input string name);
        for (int r = 0; r < SIDE; r++)
            for (int c = 0; c < SIDE; c++) begin
                int e = 0;
                if (!bg(r, c)) begin
                    e = 1000;
                    for (int rr = 0; rr < SIDE; rr++)
                        for (int cc = 0; cc < SIDE; cc++)
                            if (bg(rr, cc)) begin
                                int dr = (r > rr) ? r - rr : rr - r;
                                int dc = (c > cc) ? c - cc : cc - c;
                                int d  = (dr > dc) ? dr : dc;
                                if (d < e) e = d;
                            end
                    if (e > DMAX) e = DMAX;
                end
                push($sformatf("%s_res(%0d,%0d)", name, r, c), r, c, e);
            end
    endtask

    task automatic load_image();
        for (int a = 0; a < NPIX; a++) begin
            sti_mem[a/16][15 - (a%16)] = img[a/SIDE][a%SIDE];
            res_mem[a] = DW'($urandom);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_done"},     done,     0);
        check({tag, "_sti_rd"},   sti_rd,   0);
        check({tag, "_res_rd"},   res_rd,   0);
        check({tag, "_res_wr"},   res_wr,   0);
        check({tag, "_sti_addr"}, sti_addr, 0);
        check({tag, "_res_addr"}, res_addr, 0);
        check({tag, "_res_do"},   res_do,   0);
    endtask

    task automatic run(input string name);
        int cnt = 0;
        int obj = 0;
        int exp_cyc;
        bit seen = 1'b0;
        exp_t e;
        for (int r = 1; r < SIDE-1; r++)
            for (int c = 1; c < SIDE-1; c++)
                if (!bg(r, c)) obj++;
`ifdef DT_FAST_SKIP_EN
        exp_cyc = 1 + 18*NWORD + 2*(7*obj + 2*((SIDE-2)*(SIDE-2) - obj));
`else
        exp_cyc = 1 + 18*NWORD + 2*7*(SIDE-2)*(SIDE-2);
`endif
        load_image();
        push_model(name);
        reset = 1'b0;
        @(negedge clk);
        check_outputs_zero({name, "_rst"});
        @(negedge clk);
        reset = 1'b1;
        while (!seen && cnt < BUDGET) begin
            @(posedge clk);
            #1;
            cnt++;
            if (cnt == 1) begin
                check({name, "_first_sti_rd"},   sti_rd,   1);
                check({name, "_first_sti_addr"}, sti_addr, 0);
                check({name, "_first_res_wr"},   res_wr,   0);
            end
            if (done) seen = 1'b1;
        end
        check({name, "_done_seen"}, seen, 1);
        check({name, "_cycles"},    cnt,  exp_cyc);
        repeat (3) @(negedge clk);
        check({name, "_done_held"}, {done, sti_rd, res_rd, res_wr}, 4'b1000);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, res_mem[e.addr], e.exp);
        end
    endtask

    task automatic interrupt_at(input string name, input int r, input int c);
        int cnt = 0;
        bit hit = 1'b0;
        load_image();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        while (!hit && cnt < BUDGET) begin
            @(posedge clk);
            #1;
            cnt++;
            if (res_rd && res_addr == (2*L)'(r*SIDE + c)) hit = 1'b1;
        end
        check({name, "_reached"}, hit, 1);
        reset = 1'b0;
        #1;
        check_outputs_zero(name);
        @(negedge clk);
        check_outputs_zero({name, "_held"});
    endtask

    initial begin
        reset = 1'b1;
        #2 reset = 1'b0;
        #1 check_outputs_zero("por");

        clear_img(1'b0);
        run("zero");

        clear_img(1'b0);
        img[16][16] = 1'b1;
        push("single_centre", 16, 16, 1);
        push("single_north",  15, 16, 0);
        run("single");

        clear_img(1'b0);
        for (int r = 10; r <= 12; r++)
            for (int c = 10; c <= 12; c++)
                img[r][c] = 1'b1;
        push("block_centre", 11, 11, 2);
        push("block_corner", 10, 10, 1);
        push("block_edge",   12, 11, 1);
        run("block");

        clear_img(1'b1);
        interrupt_at("allset_int", 12, 12);
        push("allset_mid_sat", 15, 15, 7);
        push("allset_1_1",      1,  1, 1);
        push("allset_1_30",     1, 30, 1);
        push("allset_5_9",      5,  9, 5);
        push("allset_border0",  0,  7, 0);
        push("allset_border31",31, 31, 0);
        run("allset");

        check("strobe_overlap", overlap, 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
